note_delay_timer: RTL
=====================

Name: note_delay_timer

Overview:
- Multi-channel programmable delay timer; replaces the fixed-length up-counter delays (insert delay, play delay) in the datapath.
- Each channel counts down a loaded number of ticks and reports busy/done back to the controller.
- Channels are one-shot or auto-reload.
- A shared internal tick generator derives the beat rate from CLOCK_50, so no separate divided clock domain is needed.

Parameters:
- N_CH, 2, number of independent delay channels (ch0 = insert delay, ch1 = play delay).
- WIDTH, 7, bits per channel counter and load value.
- TICK_DIV, 3125000, CLOCK_50 cycles per tick (50 MHz / 16 Hz); must be >= 2.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  N_CH  per-channel start/restart request, sampled each cycle.
- abort  in  N_CH  per-channel cancel.
- mode  in  N_CH  0 = one-shot, 1 = auto-reload; sampled on start.
- load_val  in  N_CH*WIDTH  tick count per channel; channel i occupies bits [i*WIDTH +: WIDTH].
- busy  out  N_CH  channel running.
- done  out  N_CH  one-cycle pulse on expiry.
- count  out  N_CH*WIDTH  current remaining ticks.
- tick  out  1  one-cycle tick strobe, for debug and for other consumers.

Behaviour:
- Reset (async, active-high) clears all of the following to 0:
  - busy, done, count, tick
  - tick divider
  - every channel state (IDLE), reload and mode registers.
- Tick generator:
  - Divider runs 0..TICK_DIV-1 continuously.
  - tick = 1 for exactly the cycle in which the divider equals TICK_DIV-1; it then wraps to 0.
  - Period is exactly TICK_DIV cycles.
- Per-channel FSM has two states, IDLE and RUN. All outputs are registered.
- Priority in any cycle: abort > start > tick.
- abort:
  - Next cycle: state IDLE, count 0, busy 0, no done pulse.
  - Takes effect from any state, including the same cycle as start or expiry.
- start (no abort):
  - Latches load_val into count and into the reload register; latches mode.
  - If load_val != 0: RUN, busy = 1 next cycle.
  - If load_val == 0: stay or go IDLE, busy 0, done = 1 next cycle (zero-length delay still handshakes).
  - start while in RUN restarts the channel from the new load_val. A coincident tick is ignored and no done is issued for the interrupted run.
- RUN on tick:
  - count > 1: count decrements by 1.
  - count == 1, one-shot: count 0, state IDLE, busy 0, done = 1 for the following single cycle.
  - count == 1, auto-reload: count reloads from the reload register, stays RUN, busy stays 1, done = 1 for one cycle.
- IDLE ignores tick.
- The first decrement occurs at the first tick strictly after the start cycle.
  - Delay from start to done is therefore between (L-1)*TICK_DIV+1 and L*TICK_DIV cycles for L = load_val.
- start held high: re-latches every cycle, so the channel never expires. The controller must pulse start.
- Channels are fully independent. Simultaneous expiry on several channels gives simultaneous done bits.
- Arithmetic is unsigned, WIDTH bits; the decrement cannot underflow because count == 0 is never decremented.

Optional Feature:
- Macro: NOTE_DELAY_PAUSE_EN.
- With the macro defined:
  - Adds input pause [N_CH].
  - While pause[i] = 1, ticks are ignored for channel i; count and busy hold.
  - abort and start still act.
  - Releasing pause resumes on the next tick.
- Without the macro: no pause port; every tick is consumed as described above.

Decomposition:
- Shared package note_delay_pkg holds:
  - MODE_ONESHOT = 1'b0 and MODE_RELOAD = 1'b1.
  - Channel state encoding ST_IDLE / ST_RUN.
  - TICK_DIV_16HZ = 3125000.
  - Default channel indices CH_INSERT = 0 and CH_PLAY = 1.
  - Standard load values INSERT_TICKS = 6 and PLAY_TICKS = 126.
- Natural sub-module: note_tick_gen (parameter TICK_DIV; ports CLOCK_50, reset, tick), instantiated once.
- Channel logic lives in a generate loop inside note_delay_timer.

Test Plan (TICK_DIV = 4, WIDTH = 7, N_CH = 2):
- Reset mid-run: ch0 running with count 3, assert reset asynchronously between edges -> busy/count/done/tick read 0 immediately; tick resumes with 4-cycle period after release.
- One-shot: start[0] pulse, load_val 6, mode 0 -> busy[0] = 1 next cycle; count steps 6→5→…→1 on successive ticks; single-cycle done[0] after the 6th tick; busy[0] = 0, count 0.
- Auto-reload: ch1 load 3, mode 1 -> done[1] pulses after ticks 3, 6, 9; busy[1] never drops; count sequence 3,2,1,3,2,1…
- Zero load: start[0] with load_val 0 -> done[0] = 1 exactly one cycle later; busy[0] stays 0.
- Abort vs expiry: assert abort[0] in the same cycle as the expiring tick (count 1) -> no done[0], count 0, IDLE. Separately, start[1] coincident with the expiring tick -> no done, count reloads the new value.
- Pause (NOTE_DELAY_PAUSE_EN): hold pause[0] for 3 ticks at count 4 -> count holds 4; on release, expiry occurs 4 ticks later.

Source files
------------

// File: rtl/note_delay_pkg.sv
// Shared constants and types for the note delay timer: channel modes,
// channel FSM encoding, default tick rate and the standard channel setup.
package note_delay_pkg;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  localparam int TICK_DIV_16HZ = 3125000;

  localparam int CH_INSERT    = 0;
  localparam int CH_PLAY      = 1;
  localparam int INSERT_TICKS = 6;
  localparam int PLAY_TICKS   = 126;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // Per-channel control state; kept as one struct so a checker can bind to it.
  typedef struct packed {
    ch_state_e state;
    logic      mode;
  } ch_status_t;

endpackage

// File: rtl/note_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// The tick is high exactly while the divider holds TICK_DIV-1.
module note_tick_gen #(
  parameter int TICK_DIV = 3125000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d = (div_d == DIV_LAST);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/note_delay_timer.sv
// Multi-channel one-shot / auto-reload tick delay timer with a shared tick divider.
// Optional per-channel tick pause enabled by defining NOTE_DELAY_PAUSE_EN.
module note_delay_timer
  import note_delay_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int WIDTH    = 7,
  parameter int TICK_DIV = TICK_DIV_16HZ
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [N_CH-1:0]        start,
  input  logic [N_CH-1:0]        abort,
  input  logic [N_CH-1:0]        mode,
  input  logic [N_CH*WIDTH-1:0]  load_val,
`ifdef NOTE_DELAY_PAUSE_EN
  input  logic [N_CH-1:0]        pause,
`endif
  output logic [N_CH-1:0]        busy,
  output logic [N_CH-1:0]        done,
  output logic [N_CH*WIDTH-1:0]  count,
  output logic                   tick
);

  logic tick_w;

  note_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (tick_w)
  );

  assign tick = tick_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_status_t       st_q, st_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rel_q, rel_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] ld;
    logic             tick_use;

    assign ld = load_val[i*WIDTH +: WIDTH];

`ifdef NOTE_DELAY_PAUSE_EN
    assign tick_use = tick_w & ~pause[i];
`else
    assign tick_use = tick_w;
`endif

    // abort beats start beats tick; a start swallows any coincident tick.
    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      rel_d  = rel_q;
      done_d = 1'b0;
      if (abort[i]) begin
        st_d.state = ST_IDLE;
        cnt_d      = '0;
      end else if (start[i]) begin
        cnt_d     = ld;
        rel_d     = ld;
        st_d.mode = mode[i];
        if (ld != '0) begin
          st_d.state = ST_RUN;
        end else begin
          st_d.state = ST_IDLE;
          done_d     = 1'b1;
        end
      end else if (st_q.state == ST_RUN && tick_use) begin
        if (cnt_q == WIDTH'(1)) begin
          done_d = 1'b1;
          if (st_q.mode == MODE_RELOAD) begin
            cnt_d = rel_q;
          end else begin
            cnt_d      = '0;
            st_d.state = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        st_q   <= '{state: ST_IDLE, mode: MODE_ONESHOT};
        cnt_q  <= '0;
        rel_q  <= '0;
        done_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        rel_q  <= rel_d;
        done_q <= done_d;
      end
    end

    assign busy[i]                  = (st_q.state == ST_RUN);
    assign done[i]                  = done_q;
    assign count[i*WIDTH +: WIDTH]  = cnt_q;
  end

endmodule
